// File: rtl/shift_pipe_if.sv
// Handshake bundle for shift_pipe: upstream operation channel and downstream result channel.
// The design drives through the slave modport; a producer/consumer uses master.
interface shift_pipe_if #(
    parameter int N     = 32,
    parameter int TAG_W = 4
);
    localparam int S = $clog2(N);

    logic             in_valid;
    logic             in_ready;
    logic [N-1:0]     in_data;
    logic [S-1:0]     in_shamt;
    logic [1:0]       in_mode;
    logic [TAG_W-1:0] in_tag;

    logic             out_valid;
    logic             out_ready;
    logic [N-1:0]     out_data;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, in_data, in_shamt, in_mode, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_tag
    );

    modport slave (
        input  in_valid, in_data, in_shamt, in_mode, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_tag
    );
endinterface

// File: rtl/shift_pipe.sv
// Elastic log-depth barrel shifter: stage k shifts by 2^k, with per-stage bubble-collapsing back-pressure.
// Optional feature: define SHIFT_PIPE_ROTATE_EN to turn mode 11 into rotate-left; otherwise mode 11 yields 0.
module shift_pipe #(
    parameter int N     = 32,
    parameter int TAG_W = 4
) (
    input logic         clk,
    input logic         rst_n,
    shift_pipe_if.slave bus
);
    localparam int S = $clog2(N);

    typedef enum logic [1:0] {
        MODE_SLL = 2'b00,
        MODE_SRL = 2'b01,
        MODE_SRA = 2'b10,
        MODE_ROL = 2'b11
    } mode_e;

    // One conditional shift step; reserved mode 11 forces zero at every step so the result is 0.
    function automatic logic [N-1:0] shift_step(input logic [N-1:0] d, input logic en,
                                                input logic [1:0] mode, input int amt);
        logic signed [N-1:0] sd;
        logic [N-1:0]        r;
        sd = d;
        r  = d;
        case (mode)
            MODE_SLL: if (en) r = d << amt;
            MODE_SRL: if (en) r = d >> amt;
            MODE_SRA: if (en) r = sd >>> amt;
            default: begin
`ifdef SHIFT_PIPE_ROTATE_EN
                if (en) r = (d << amt) | (d >> (N - amt));
`else
                r = '0;
`endif
            end
        endcase
        return r;
    endfunction

    logic [S-1:0]     vld_p;
    logic [N-1:0]     data_p  [S];
    logic [TAG_W-1:0] tag_p   [S];
    logic [S-1:0]     shamt_p [S-1];
    logic [1:0]       mode_p  [S-1];

    logic [S-1:0]     src_vld;
    logic [N-1:0]     src_data  [S];
    logic [TAG_W-1:0] src_tag   [S];
    logic [S-1:0]     src_shamt [S];
    logic [1:0]       src_mode  [S];

    logic [S:0]       ld;

    // ld[k]: stage k captures this cycle; ld[S] is the downstream accept.
    always_comb begin
        ld[S] = bus.out_ready;
        for (int k = S - 1; k >= 0; k--) begin
            ld[k] = !vld_p[k] || ld[k+1];
        end
    end

    always_comb begin
        src_vld[0]   = bus.in_valid;
        src_data[0]  = bus.in_data;
        src_tag[0]   = bus.in_tag;
        src_shamt[0] = bus.in_shamt;
        src_mode[0]  = bus.in_mode;
        for (int k = 1; k < S; k++) begin
            src_vld[k]   = vld_p[k-1];
            src_data[k]  = data_p[k-1];
            src_tag[k]   = tag_p[k-1];
            src_shamt[k] = shamt_p[k-1];
            src_mode[k]  = mode_p[k-1];
        end
    end

    // Stage registers p0..p(S-1); a stage only changes when it loads, so held entries stay stable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < S; k++) begin
                vld_p[k]  <= 1'b0;
                data_p[k] <= '0;
                tag_p[k]  <= '0;
            end
            for (int k = 0; k < S - 1; k++) begin
                shamt_p[k] <= '0;
                mode_p[k]  <= '0;
            end
        end else begin
            for (int k = 0; k < S; k++) begin
                if (ld[k]) begin
                    vld_p[k]  <= src_vld[k];
                    data_p[k] <= shift_step(src_data[k], src_shamt[k][k], src_mode[k], 1 << k);
                    tag_p[k]  <= src_tag[k];
                end
            end
            for (int k = 0; k < S - 1; k++) begin
                if (ld[k]) begin
                    shamt_p[k] <= src_shamt[k];
                    mode_p[k]  <= src_mode[k];
                end
            end
        end
    end

    assign bus.in_ready  = ld[0];
    assign bus.out_valid = vld_p[S-1];
    assign bus.out_data  = data_p[S-1];
    assign bus.out_tag   = tag_p[S-1];
endmodule

// File: tb/tb_shift_pipe.sv
// Directed bench for shift_pipe (N=32, TAG_W=4): latency, throughput, back-pressure, reset flush, mode 11.
module tb_shift_pipe;
    typedef struct {
        logic [31:0] d;
        logic [4:0]  sh;
        logic [1:0]  m;
        logic [3:0]  t;
        logic [31:0] exp;
    } op_t;

    logic clk;
    logic rst_n;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    logic [31:0] out_d_q[$];
    logic [3:0]  out_t_q[$];
    int          out_c_q[$];
    int          acc_c_q[$];

    op_t tab[7];

    shift_pipe_if #(.N(32), .TAG_W(4)) bus ();

    shift_pipe #(.N(32), .TAG_W(4)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every transfer on both sides with the edge number at which it happened.
    always @(posedge clk) begin
        if (rst_n && bus.in_valid && bus.in_ready) acc_c_q.push_back(cyc);
        if (rst_n && bus.out_valid && bus.out_ready) begin
            out_d_q.push_back(bus.out_data);
            out_t_q.push_back(bus.out_tag);
            out_c_q.push_back(cyc);
        end
    end

    function automatic op_t mk(input logic [31:0] d, input logic [4:0] sh, input logic [1:0] m,
                               input logic [3:0] t, input logic [31:0] exp);
        op_t o;
        o.d = d; o.sh = sh; o.m = m; o.t = t; o.exp = exp;
        return o;
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_q();
        out_d_q.delete();
        out_t_q.delete();
        out_c_q.delete();
        acc_c_q.delete();
    endtask

    // Called at posedge+1; offers one operation until accepted (bounded).
    task automatic push(input op_t o);
        int budget;
        bit acc;
        budget = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = o.d;
        bus.in_shamt = o.sh;
        bus.in_mode  = o.m;
        bus.in_tag   = o.t;
        do begin
            #3;
            acc = bus.in_ready;
            step();
            budget++;
        end while (!acc && budget < 40);
        if (!acc) check_eq("push_accept", acc, 1);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_outs(input string tag, input int n);
        int budget;
        budget = 0;
        while (out_d_q.size() < n && budget < 60) begin
            step();
            budget++;
        end
        check_eq(tag, out_d_q.size(), n);
    endtask

    task automatic expect_res(input string tag, input int k, input op_t o);
        if (k < out_d_q.size()) begin
            check_eq(tag, out_d_q[k], o.exp);
            check_eq({tag, "_tag"}, out_t_q[k], o.t);
        end else begin
            check_eq({tag, "_present"}, out_d_q.size(), k + 1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        op_t a, b, c, r;

        tab[0] = mk(32'h0000_0001, 5'd1,  2'b00, 4'h1, 32'h0000_0002);
        tab[1] = mk(32'h0000_0100, 5'd4,  2'b01, 4'h2, 32'h0000_0010);
        tab[2] = mk(32'hFFFF_0000, 5'd16, 2'b10, 4'h3, 32'hFFFF_FFFF);
        tab[3] = mk(32'h0000_0003, 5'd8,  2'b00, 4'h4, 32'h0000_0300);
        tab[4] = mk(32'h8000_0000, 5'd31, 2'b01, 4'h5, 32'h0000_0001);
        tab[5] = mk(32'h8000_0000, 5'd0,  2'b10, 4'h6, 32'h8000_0000);
        tab[6] = mk(32'hDEAD_BEEF, 5'd0,  2'b00, 4'h7, 32'hDEAD_BEEF);

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_shamt  = '0;
        bus.in_mode   = '0;
        bus.in_tag    = '0;
        bus.out_ready = 1'b0;

        #12;
        check_eq("rst_out_valid", bus.out_valid, 0);
        check_eq("rst_out_data", bus.out_data, 0);
        check_eq("rst_out_tag", bus.out_tag, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check_eq("rel_in_ready", bus.in_ready, 1);
        check_eq("rel_out_valid", bus.out_valid, 0);

        // SRA sign fill and transfer-to-transfer latency
        clear_q();
        bus.out_ready = 1'b1;
        a = mk(32'h8000_0000, 5'd4, 2'b10, 4'h3, 32'hF800_0000);
        push(a);
        wait_outs("sra_count", 1);
        expect_res("sra_data", 0, a);
        if (out_c_q.size() > 0 && acc_c_q.size() > 0)
            check_eq("sra_latency", out_c_q[0] - acc_c_q[0], 5);

        // back-to-back issue, results on consecutive cycles
        clear_q();
        a = mk(32'h0000_0001, 5'd31, 2'b00, 4'h8, 32'h8000_0000);
        b = mk(32'hF000_0000, 5'd28, 2'b01, 4'h9, 32'h0000_000F);
        c = mk(32'h0000_00A5, 5'd0,  2'b00, 4'hA, 32'h0000_00A5);
        push(a);
        push(b);
        push(c);
        wait_outs("b2b_count", 3);
        expect_res("b2b_sll31", 0, a);
        expect_res("b2b_srl28", 1, b);
        expect_res("b2b_sll0", 2, c);
        if (out_c_q.size() == 3) begin
            check_eq("b2b_gap01", out_c_q[1] - out_c_q[0], 1);
            check_eq("b2b_gap12", out_c_q[2] - out_c_q[1], 1);
        end

        // back-pressure: exactly five accepts, hold, then drain in order
        clear_q();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) push(tab[i]);
        check_eq("fill_accepts", acc_c_q.size(), 5);
        bus.in_valid = 1'b1;
        bus.in_data  = tab[5].d;
        bus.in_shamt = tab[5].sh;
        bus.in_mode  = tab[5].m;
        bus.in_tag   = tab[5].t;
        #3;
        check_eq("full_in_ready", bus.in_ready, 0);
        for (int i = 0; i < 3; i++) step();
        check_eq("stall_accepts", acc_c_q.size(), 5);
        check_eq("stall_out_valid", bus.out_valid, 1);
        check_eq("stall_out_data", bus.out_data, tab[0].exp);
        check_eq("stall_out_tag", bus.out_tag, tab[0].t);
        bus.out_ready = 1'b1;
        push(tab[5]);
        push(tab[6]);
        wait_outs("bp_count", 7);
        for (int i = 0; i < 7; i++) expect_res($sformatf("bp_res%0d", i), i, tab[i]);

        // simultaneous accept and drain while full
        clear_q();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) push(tab[i]);
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = tab[5].d;
        bus.in_shamt  = tab[5].sh;
        bus.in_mode   = tab[5].m;
        bus.in_tag    = tab[5].t;
        #3;
        check_eq("full_swap_in_ready", bus.in_ready, 1);
        step();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        check_eq("swap_accepts", acc_c_q.size(), 6);
        check_eq("swap_drains", out_d_q.size(), 1);
        check_eq("swap_occupancy", acc_c_q.size() - out_d_q.size(), 5);
        #1;
        check_eq("swap_still_full", bus.in_ready, 0);
        bus.out_ready = 1'b1;
        wait_outs("swap_count", 6);
        for (int i = 0; i < 6; i++) expect_res($sformatf("swap_res%0d", i), i, tab[i]);

        // reset with operations in flight
        clear_q();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) push(tab[i]);
        for (int i = 0; i < 3; i++) step();
        check_eq("pre_rst_out_valid", bus.out_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_out_valid", bus.out_valid, 0);
        check_eq("mid_rst_out_data", bus.out_data, 0);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        step();
        check_eq("post_rst_in_ready", bus.in_ready, 1);
        for (int i = 0; i < 10; i++) step();
        check_eq("no_stale_results", out_d_q.size(), 0);
        check_eq("post_rst_out_valid", bus.out_valid, 0);

        // mode 11: rotate when enabled, zero when reserved
        clear_q();
`ifdef SHIFT_PIPE_ROTATE_EN
        r = mk(32'h8000_0001, 5'd1, 2'b11, 4'hC, 32'h0000_0003);
`else
        r = mk(32'h8000_0001, 5'd1, 2'b11, 4'hC, 32'h0000_0000);
`endif
        push(r);
        wait_outs("mode11_count", 1);
        expect_res("mode11_data", 0, r);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
